cache_mem_arbiter: RTL and testbench

- Shares the single backing-memory port between the CPUMIPS instruction-cache miss path and the data-cache miss/write path.
- Accepts one transaction at a time: I-line read, D-line read, or D-word write.
- Sequences the memory req/ack handshake and returns the 128-bit line to the requester that owns the transaction.
- Sits between the two cache controllers and the memory model, and supplies the ii_miss_data / id_miss_data lines the core consumes.

---
 rtl/cache_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single backing-memory port between I-cache line reads and D-cache reads/writes.
// Optional build macro ARB_ROUND_ROBIN_EN swaps fixed D priority + starvation guard for round-robin.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned LINE_W       = 128,
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_done,
    output logic [LINE_W-1:0] i_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [LINE_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [WORD_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [LINE_W-1:0] m_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam logic [ADDR_W-1:0] LineMask = ~ADDR_W'(15);

    state_e            state_q, state_d;
    logic              owner_i_q, owner_i_d;
    logic              i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
    logic              i_done_q, i_done_d, d_done_q, d_done_d;
    logic [LINE_W-1:0] i_data_q, i_data_d, d_rdata_q, d_rdata_d;
    logic              m_req_q, m_req_d, m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [WORD_W-1:0] m_wdata_q, m_wdata_d;
    logic              busy_q, busy_d;
    logic              i_wins;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_i_q, last_i_d;

    // On contention, the requester that did not win last time goes first.
    assign i_wins = i_req && (!d_req || !last_i_q);
`else
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] starve_q, starve_d;

    assign i_wins = i_req && (!d_req || (starve_q >= CntW'(STARVE_LIMIT)));
`endif

    always_comb begin
        state_d   = state_q;
        owner_i_d = owner_i_q;
        i_gnt_d   = 1'b0;
        d_gnt_d   = 1'b0;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        i_data_d  = i_data_q;
        d_rdata_d = d_rdata_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_i_d  = last_i_q;
`else
        starve_d  = starve_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    state_d   = StWait;
                    m_req_d   = 1'b1;
                    owner_i_d = i_wins;
                    if (i_wins) begin
                        i_gnt_d  = 1'b1;
                        m_we_d   = 1'b0;
                        m_addr_d = i_addr & LineMask;
                    end else begin
                        d_gnt_d  = 1'b1;
                        m_we_d   = d_we;
                        m_addr_d = d_we ? d_addr : (d_addr & LineMask);
                        if (d_we) begin
                            m_wdata_d = d_wdata;
                        end
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_i_d = i_wins;
`else
                    // Count D grants that leave a pending I waiting.
                    if (i_wins || !i_req) begin
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + CntW'(1);
                    end
`endif
                end
            end
            StWait: begin
                if (m_ack) begin
                    state_d = StResp;
                    m_req_d = 1'b0;
                    if (owner_i_q) begin
                        i_done_d = 1'b1;
                        i_data_d = m_rdata;
                    end else begin
                        d_done_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = m_rdata;
                        end
                    end
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            owner_i_q <= 1'b1;
            i_gnt_q   <= 1'b0;
            d_gnt_q   <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            busy_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_i_q  <= 1'b1;
`else
            starve_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            owner_i_q <= owner_i_d;
            i_gnt_q   <= i_gnt_d;
            d_gnt_q   <= d_gnt_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            i_data_q  <= i_data_d;
            d_rdata_q <= d_rdata_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            busy_q    <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_i_q  <= last_i_d;
`else
            starve_q  <= starve_d;
`endif
        end
    end

    assign i_gnt   = i_gnt_q;
    assign d_gnt   = d_gnt_q;
    assign i_done  = i_done_q;
    assign d_done  = d_done_q;
    assign i_data  = i_data_q;
    assign d_rdata = d_rdata_q;
    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized transactions
// checked against a grant-order / returned-data reference model.
module tb_cache_mem_arbiter;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned LINE_W       = 128;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0, d_addr = '0;
    logic [WORD_W-1:0] d_wdata = '0;
    logic [LINE_W-1:0] m_rdata = '0;
    logic              i_gnt, i_done, d_gnt, d_done, m_req, m_we, busy;
    logic [LINE_W-1:0] i_data, d_rdata;
    logic [ADDR_W-1:0] m_addr;
    logic [WORD_W-1:0] m_wdata;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                starve_m = 0;
    bit                last_i_m = 1'b1;
    logic [LINE_W-1:0] exp_idata = '0, exp_drdata = '0;

    cache_mem_arbiter #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .WORD_W(WORD_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_data(i_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One complete arbitration + memory transaction; returns the DUT's i_gnt at grant time.
    task automatic do_txn(input bit ir, input bit dr, input bit we, input logic [31:0] ia,
                          input logic [31:0] da, input logic [31:0] dw,
                          input logic [LINE_W-1:0] line, input int delay, output bit i_gnt_seen);
        logic [31:0] exp_addr;
        bit          iw;
        i_req = ir; i_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = dw;
        tick;
        i_req = 1'b0; d_req = 1'b0;
        i_gnt_seen = i_gnt;
        if (!ir && !dr) begin
            check("noreq_busy", busy, 0);
            check("noreq_gnt", {i_gnt, d_gnt}, 0);
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            iw = ir && (!dr || !last_i_m);
            last_i_m = iw;
`else
            iw = ir && (!dr || starve_m >= STARVE_LIMIT);
            if (iw || !ir) starve_m = 0;
            else starve_m++;
`endif
            exp_addr = iw ? {ia[31:4], 4'h0} : (we ? da : {da[31:4], 4'h0});
            check("i_gnt", i_gnt, iw);
            check("d_gnt", d_gnt, !iw);
            check("m_req_on", m_req, 1);
            check("busy_on", busy, 1);
            check("m_addr", m_addr, exp_addr);
            check("m_we", m_we, !iw && we);
            if (!iw && we) check("m_wdata", m_wdata, dw);
            for (int k = 0; k < delay; k++) begin
                tick;
                check("wait_hold", {m_req, m_we, m_addr}, {1'b1, !iw && we, exp_addr});
                check("wait_gnt_pulse", {i_gnt, d_gnt, i_done, d_done}, 0);
            end
            m_ack = 1'b1; m_rdata = line;
            // Requests coinciding with the ack must be ignored.
            i_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1));
            tick;
            m_ack = 1'b0; i_req = 1'b0; d_req = 1'b0;
            if (iw) exp_idata = line;
            else if (!we) exp_drdata = line;
            check("i_done", i_done, iw);
            check("d_done", d_done, !iw);
            check("m_req_off", m_req, 0);
            check("resp_no_gnt", {i_gnt, d_gnt}, 0);
            check("i_data", i_data, exp_idata);
            check("d_rdata", d_rdata, exp_drdata);
            tick;
            check("resp_exit", {busy, i_done, d_done, i_gnt, d_gnt, m_req}, 0);
        end
    endtask

    initial begin
        bit          won;
        bit          order [6];
        logic [31:0] a;
        #1;
        check("rst_ctrl", {i_gnt, i_done, d_gnt, d_done, m_req, m_we, busy}, 0);
        check("rst_i_data", i_data, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        #12 rstn = 1'b1;
        tick;

        // I line read, ack two cycles after m_req
        do_txn(1, 0, 0, 32'h0000_0014, 32'h0, 32'h0,
               {32'h0021_0820, 32'h0000_0020, 32'h0000_0020, 32'h0043_0820}, 2, won);
        check("i_read_line", i_data, {32'h0021_0820, 32'h0000_0020, 32'h0000_0020, 32'h0043_0820});

        // D word write, ack on first WAIT cycle
        do_txn(0, 1, 1, 32'h0, 32'h0000_0108, 32'hDEAD_BEEF, rand_line(), 0, won);

        // Stray ack in IDLE
        m_ack = 1'b1; m_rdata = rand_line();
        tick;
        m_ack = 1'b0;
        check("stray_ctrl", {busy, i_gnt, d_gnt, i_done, d_done, m_req}, 0);
        check("stray_i_data", i_data, exp_idata);
        check("stray_d_rdata", d_rdata, exp_drdata);
        do_txn(1, 0, 0, $urandom, 32'h0, 32'h0, rand_line(), 1, won);

        // Contention, both requesters re-raised after every grant
`ifdef ARB_ROUND_ROBIN_EN
        order = '{0, 1, 0, 1, 0, 1};
`else
        order = '{0, 0, 0, 0, 1, 0};
`endif
        for (int g = 0; g < 6; g++) begin
            do_txn(1, 1, 0, $urandom, $urandom, $urandom, rand_line(),
                   $urandom_range(0, 2), won);
            check($sformatf("contention_%0d", g), won, order[g]);
        end

        // Reset while WAIT, then a late ack
        a = $urandom;
        i_req = 1'b1; i_addr = a;
        tick;
        i_req = 1'b0;
        check("midop_m_req", m_req, 1);
        #2 rstn = 1'b0;
        #1;
        check("midop_rst_ctrl", {m_req, busy, i_gnt, d_gnt, i_done, d_done}, 0);
        check("midop_rst_data", {i_data, d_rdata}, 0);
        starve_m = 0; last_i_m = 1'b1; exp_idata = '0; exp_drdata = '0;
        tick;
        #2 rstn = 1'b1;
        tick;
        m_ack = 1'b1; m_rdata = rand_line();
        tick;
        m_ack = 1'b0;
        check("late_ack_done", {i_done, d_done}, 0);
        check("late_ack_busy", {busy, m_req}, 0);
        tick;
        check("late_ack_idle", busy, 0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            do_txn($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, rand_line(),
                   $urandom_range(0, 3), won);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
